// File: rtl/video_sync_gen.sv
// Synthetic video timing source: sync, burst and field decodes, plus a target-rectangle flag.
// Optional `TRACK_SIM_EN` lets tracker az/el outputs move the target once per field.
module video_sync_gen #(
  parameter int LINE_CLKS       = 254,
  parameter int HSYNC_CLKS      = 19,
  parameter int BURST_START     = 21,
  parameter int BURST_CLKS      = 9,
  parameter int LINES_PER_FIELD = 262,
  parameter int VSYNC_LINES     = 9,
  parameter int TGT_LINE        = 128,
  parameter int TGT_COL         = 120,
  parameter int TGT_W           = 3,
  parameter int TGT_H           = 4
) (
  input  logic       clk4mhz,
  input  logic       reset,
  input  logic       pos_load,
  input  logic [8:0] pos_line,
  input  logic [8:0] pos_col,
`ifdef TRACK_SIM_EN
  input  logic       az_dir,
  input  logic       el_dir,
  input  logic       az_fast,
  input  logic       el_fast,
`endif
  output logic       pos_busy,
  output logic       pos_ack,
  output logic       vsync,
  output logic       csync,
  output logic       field,
  output logic       burst,
  output logic       target
);

  localparam logic [9:0] H_LAST  = 10'(LINE_CLKS - 1);
  localparam logic [9:0] V_LAST  = 10'(LINES_PER_FIELD - 1);
  localparam logic [9:0] HS_L    = 10'(HSYNC_CLKS);
  localparam logic [9:0] VS_L    = 10'(VSYNC_LINES);
  localparam logic [9:0] BS_LO   = 10'(BURST_START);
  localparam logic [9:0] BS_HI   = 10'(BURST_START + BURST_CLKS - 1);
  localparam logic [9:0] TW_M1   = 10'(TGT_W - 1);
  localparam logic [9:0] TH_M1   = 10'(TGT_H - 1);
  localparam logic [8:0] LINE_R  = 9'(TGT_LINE);
  localparam logic [8:0] COL_R   = 9'(TGT_COL);

  logic [9:0] h_cnt, v_cnt;
  logic       field_st;
  logic [8:0] cur_line, cur_col, pend_line, pend_col;
  logic       field_start;
  logic       cs_d, vs_d, bst_d, tgt_d;
  logic [9:0] act_col, act_line, line_lo, line_hi, col_lo, col_hi;

  assign field_start = (h_cnt == '0) && (v_cnt == '0);

  // Range ends are 10-bit sums so rectangles hanging off the field never wrap into view.
  always_comb begin
    cs_d     = h_cnt < HS_L;
    vs_d     = v_cnt < VS_L;
    act_col  = h_cnt - HS_L;
    act_line = v_cnt - VS_L;
    line_lo  = {1'b0, cur_line};
    line_hi  = line_lo + TH_M1;
    col_lo   = {1'b0, cur_col};
    col_hi   = col_lo + TW_M1;
    bst_d    = (h_cnt >= BS_LO) && (h_cnt <= BS_HI) && !vs_d;
    tgt_d    = !cs_d && !vs_d &&
               (act_line >= line_lo) && (act_line <= line_hi) &&
               (act_col >= col_lo) && (act_col <= col_hi);
  end

`ifdef TRACK_SIM_EN
  localparam logic [9:0] COL_MAX  = 10'(LINE_CLKS - HSYNC_CLKS - TGT_W);
  localparam logic [9:0] LINE_MAX = 10'(LINES_PER_FIELD - VSYNC_LINES - TGT_H);

  function automatic logic [8:0] move(input logic [8:0] cur, input logic dir,
                                      input logic fast, input logic [9:0] hi);
    logic signed [11:0] s, n;
    s = fast ? 12'sd4 : 12'sd1;
    n = $signed({3'b000, cur}) + (dir ? s : -s);
    if (n < 12'sd0)                       move = '0;
    else if (n > $signed({2'b00, hi}))    move = hi[8:0];
    else                                  move = n[8:0];
  endfunction
`endif

  always_ff @(posedge clk4mhz or posedge reset) begin
    if (reset) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      field_st  <= 1'b0;
      field     <= 1'b0;
      csync     <= 1'b0;
      vsync     <= 1'b0;
      burst     <= 1'b0;
      target    <= 1'b0;
      cur_line  <= LINE_R;
      cur_col   <= COL_R;
      pend_line <= '0;
      pend_col  <= '0;
      pos_busy  <= 1'b0;
      pos_ack   <= 1'b0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt    <= '0;
          field_st <= ~field_st;
        end else begin
          v_cnt <= v_cnt + 10'd1;
        end
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end

      csync  <= cs_d;
      vsync  <= vs_d;
      burst  <= bst_d;
      target <= tgt_d;
      field  <= field_st;

      pos_ack <= field_start && pos_busy;
      if (field_start && pos_busy) begin
        cur_line <= pend_line;
        cur_col  <= pend_col;
        pos_busy <= 1'b0;
      end
`ifdef TRACK_SIM_EN
      else if (field_start) begin
        cur_col  <= move(cur_col, az_dir, az_fast, COL_MAX);
        cur_line <= move(cur_line, el_dir, el_fast, LINE_MAX);
      end
`endif
      // A load on the apply clock becomes the next pending value, so busy stays set.
      if (pos_load) begin
        pend_line <= pos_line;
        pend_col  <= pos_col;
        pos_busy  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_sync_gen.sv
// Bench for video_sync_gen at reduced line/field sizes; every clock is compared
// against a reference computed from the clock index since reset.
module tb_video_sync_gen;
  localparam int L  = 40, HS = 5, BS = 7, BC = 4;
  localparam int F  = 30, VS = 3, TL = 10, TC = 12, W = 3, H = 4;
  localparam int FIELD = L * F;

  logic       clk4mhz = 1'b0, reset = 1'b1, pos_load = 1'b0;
  logic [8:0] pos_line = '0, pos_col = '0;
  logic       pos_busy, pos_ack, vsync, csync, field, burst, target;
`ifdef TRACK_SIM_EN
  logic az_dir = 1'b0, el_dir = 1'b0, az_fast = 1'b0, el_fast = 1'b0;
`endif

  video_sync_gen #(.LINE_CLKS(L), .HSYNC_CLKS(HS), .BURST_START(BS), .BURST_CLKS(BC),
                   .LINES_PER_FIELD(F), .VSYNC_LINES(VS), .TGT_LINE(TL), .TGT_COL(TC),
                   .TGT_W(W), .TGT_H(H)) dut (
    .clk4mhz(clk4mhz), .reset(reset), .pos_load(pos_load), .pos_line(pos_line),
    .pos_col(pos_col),
`ifdef TRACK_SIM_EN
    .az_dir(az_dir), .el_dir(el_dir), .az_fast(az_fast), .el_fast(el_fast),
`endif
    .pos_busy(pos_busy), .pos_ack(pos_ack), .vsync(vsync), .csync(csync),
    .field(field), .burst(burst), .target(target));

  always #5 clk4mhz = ~clk4mhz;

  int checks = 0, failures = 0;
  int k = 0;                       // clocks since reset release
  int m_line = TL, m_col = TC, m_pl = 0, m_pc = 0;
  bit m_busy = 0;
  int tgt_seen = 0, ack_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction

  // One clock: drive inputs, predict, clock, compare, advance the reference.
  task automatic step(input bit ld, input int pl, input int pc);
    int h, v, al, ac;
    bit cs, vs, bu, tg, fs, ak, fl;
    pos_load = ld;
    pos_line = pl[8:0];
    pos_col  = pc[8:0];
    h  = k % L;
    v  = (k / L) % F;
    fl = ((k / FIELD) % 2) == 1;
    fs = (h == 0) && (v == 0);
    cs = h < HS;
    vs = v < VS;
    bu = (h >= BS) && (h < BS + BC) && !vs;
    al = v - VS;
    ac = h - HS;
    tg = !cs && !vs && al >= m_line && al < m_line + H && ac >= m_col && ac < m_col + W;
    ak = fs && m_busy;
    @(posedge clk4mhz);
    #1;
    pos_load = 1'b0;
    if (fs && m_busy) begin
      m_line = m_pl; m_col = m_pc; m_busy = 0;
    end
`ifdef TRACK_SIM_EN
    else if (fs) begin
      m_col  = clampi(m_col  + (az_dir ? 1 : -1) * (az_fast ? 4 : 1), L - HS - W);
      m_line = clampi(m_line + (el_dir ? 1 : -1) * (el_fast ? 4 : 1), F - VS - H);
    end
`endif
    if (ld) begin
      m_pl = pl % 512; m_pc = pc % 512; m_busy = 1;
    end
    chk("csync", csync, cs);
    chk("vsync", vsync, vs);
    chk("burst", burst, bu);
    chk("field", field, fl);
    chk("target", target, tg);
    chk("pos_ack", pos_ack, ak);
    chk("pos_busy", pos_busy, m_busy);
    tgt_seen += int'(target);
    ack_seen += int'(pos_ack);
    k++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic to_field_start();
    while (k % FIELD != 0) step(0, 0, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_csync"}, csync, 0);
    chk({tag, "_vsync"}, vsync, 0);
    chk({tag, "_burst"}, burst, 0);
    chk({tag, "_field"}, field, 0);
    chk({tag, "_target"}, target, 0);
    chk({tag, "_ack"}, pos_ack, 0);
    chk({tag, "_busy"}, pos_busy, 0);
  endtask

  initial begin
    #2 chk_reset_outputs("rst");
    #20 reset = 1'b0;

    // Two default fields: 12 target clocks each, one field toggle.
    tgt_seen = 0;
    idle(2 * FIELD);
    chk("default_tgt_count", tgt_seen, 24);

    // Mid-field load applies at the next field start with exactly one ack.
    idle(FIELD / 3);
    ack_seen = 0;
    step(1, 5, 6);
    to_field_start();
    tgt_seen = 0;
    idle(FIELD);
    chk("load_ack_count", ack_seen, 1);
    chk("load_tgt_count", tgt_seen, 12);

    // Overwrite within one field: last wins, single ack.
    idle(100);
    ack_seen = 0;
    step(1, 1, 1);
    idle(200);
    step(1, 20, 25);
    to_field_start();
    idle(FIELD);
    chk("overwrite_ack_count", ack_seen, 1);

    // Load colliding with a field-start apply.
    idle(300);
    step(1, 7, 8);
    to_field_start();
    step(1, 15, 16);
    idle(2 * FIELD - 1);

    // Randomized loads, including positions off the visible area.
    for (int i = 0; i < 4 * FIELD; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        if ($urandom_range(0, 3) == 0) step(1, $urandom_range(0, 511), $urandom_range(0, 511));
        else                           step(1, $urandom_range(0, F - VS), $urandom_range(0, L - HS));
      end else step(0, 0, 0);
    end

    // Async reset mid-field with a pending load: pending discarded, no ack.
    to_field_start();
    idle(50);
    step(1, 3, 4);
    idle(100);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(posedge clk4mhz); #1 chk_reset_outputs("midrst_hold");
    #3 reset = 1'b0;
    k = 0; m_line = TL; m_col = TC; m_busy = 0;
    ack_seen = 0; tgt_seen = 0;
    idle(FIELD + 5);
    chk("post_rst_ack_count", ack_seen, 0);
    chk("post_rst_tgt_count", tgt_seen, 12);

`ifdef TRACK_SIM_EN
    // Tracker-driven motion: col +4, line -1 per field; col saturates.
    az_dir = 1'b1; az_fast = 1'b1; el_dir = 1'b0; el_fast = 1'b0;
    to_field_start();
    idle(7 * FIELD);
    chk("track_col", m_col, L - HS - W);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_sync_gen.md
Name: video_sync_gen

Overview:
- Synthetic video-timing source for bench and in-system self-test of the target tracker.
- Generates vsync, csync, field and burst at the 4 MHz column-clock granularity the tracker counts in.
- Generates a target flag marking a programmable rectangular blob, so the tracker's detection and az/el outputs can be exercised without a camera or sync separator.
- Sits in place of the sync-separator and comparator front end; the target flag drives both tracker target inputs.

Parameters:
- LINE_CLKS, 254, clocks per line (63.5 us at 4 MHz)
- HSYNC_CLKS, 19, csync-high clocks at line start
- BURST_START, 21, h_cnt of first burst-high clock
- BURST_CLKS, 9, burst width in clocks
- LINES_PER_FIELD, 262, lines per field
- VSYNC_LINES, 9, lines per field with vsync high
- TGT_LINE, 128, reset target top (active-line index)
- TGT_COL, 120, reset target left (active-column index)
- TGT_W, 3, target width in clocks (1..4 for tracker acceptance)
- TGT_H, 4, target height in lines

Ports:
- clk4mhz  in  1  4 MHz clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- pos_load  in  1  one-clock strobe; capture pos_line/pos_col
- pos_line  in  9  requested target top, active-line index
- pos_col  in  9  requested target left, active-column index
- pos_busy  out  1  a captured position is pending
- pos_ack  out  1  one-clock pulse when the pending position takes effect
- vsync  out  1  high during vertical interval lines
- csync  out  1  high during hsync
- field  out  1  toggles every field
- burst  out  1  burst-gate window
- target  out  1  high inside target rectangle

Behaviour:
- Counters:
  - h_cnt: 0..LINE_CLKS-1, wraps to 0.
  - v_cnt: 0..LINES_PER_FIELD-1, increments when h_cnt wraps; wraps to 0 and toggles field.
  - Field start is h_cnt=0 and v_cnt=0.
- Decodes:
  - act_col = h_cnt-HSYNC_CLKS.
  - act_line = v_cnt-VSYNC_LINES.
  - Both are valid only when csync=0 and vsync=0.
- All outputs are registered decodes of the same counter state. They share a uniform one-clock latency with no inter-output skew.
  - csync = (h_cnt < HSYNC_CLKS).
  - vsync = (v_cnt < VSYNC_LINES).
  - burst = h_cnt in [BURST_START, BURST_START+BURST_CLKS-1] and vsync=0.
  - target = vsync=0, csync=0, act_line in [cur_line, cur_line+TGT_H-1], act_col in [cur_col, cur_col+TGT_W-1].
- Range sums are computed at 10 bits, with no wrap. Rows or columns beyond the field or line simply never match.
- Position handshake:
  - pos_load=1 captures pos_line/pos_col into the pending register and sets pos_busy.
  - At the next field start with pos_busy=1: cur_line/cur_col take the pending value, pos_busy clears, and pos_ack pulses for one clock. The rectangle never changes mid-field.
  - A load while busy overwrites pending (last wins); a single ack is issued.
  - A load in the same clock as a field-start apply: the old pending value is applied and acked; the new value becomes pending, pos_busy stays 1, and it is applied at the following field start.
- Reset (async):
  - h_cnt=0, v_cnt=0, field=0.
  - cur_line=TGT_LINE, cur_col=TGT_COL.
  - pos_busy=0, pos_ack=0.
  - All sync/target outputs 0.
  - First clock after release: outputs reflect h_cnt=0, v_cnt=0, i.e. csync=1, vsync=1.
- Reset mid-field discards any pending position with no ack.

Optional Feature:
- Macro: TRACK_SIM_EN.
- Defined:
  - Adds inputs az_dir, el_dir, az_fast, el_fast (1 bit each, wired from the tracker az/el/speed outputs).
  - At each field start with pos_busy=0, cur_col moves by +step if az_dir=1 and -step otherwise.
  - cur_line moves by +step if el_dir=1 and -step otherwise.
  - step = 4 when the respective fast input is 1, else 1.
  - Saturation: cur_col to [0, LINE_CLKS-HSYNC_CLKS-TGT_W]; cur_line to [0, LINES_PER_FIELD-VSYNC_LINES-TGT_H].
  - A pending load takes priority over motion in that field.
- Undefined: no extra ports; the position changes only through the load handshake.

Test Plan:
- Timing: release reset, run 2 fields.
  - csync high for 19 of every 254 clocks.
  - vsync high for 9 lines of 262.
  - field toggles every 66548 clocks.
  - burst high at h_cnt 21..29, never while vsync=1.
- Default target: target high only for act_line 128..131 and act_col 120..122 → exactly 12 target clocks per field.
- Handshake: pos_load with line 50, col 60 mid-field.
  - pos_busy=1; rectangle unchanged this field.
  - At next field start, pos_ack pulses once and pos_busy=0.
  - Target then appears at lines 50..53, cols 60..62.
- Overwrite and collision:
  - Loads (10,10) then (20,20) in one field → single ack; target at 20/20.
  - Load coinciding with field start → applied one field later, pos_busy held through.
- Reset mid-field with pending load: all outputs 0 during reset, pos_busy=0, no ack; target back at 128/120.
- TRACK_SIM_EN: az_dir=1, az_fast=1, el_dir=0, el_fast=0 held 3 fields from 128/120 → col 132, 136, 140 and line 127, 126, 125. Col saturates at 232 when driven up long enough.
